servant_multi_timer: RTL and testbench

- Multi-channel Wishbone timer peripheral for the servant SoC. Successor to the single-channel slow timer.
- CHANNELS independent WIDTH-bit counters run off a shared, prescaled slow-clock tick. All logic is in the i_clk domain.
- Each channel has a compare register, enable, one-shot/periodic mode, interrupt enable and a sticky pending flag. Per-channel irq lines are ORed onto o_irq for the SERV core.

---
 rtl/servant_multi_timer.sv | 235 +++++++++++++++++++++++
 tb/tb_servant_multi_timer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_multi_timer.sv
// servant_multi_timer
//   Multi-channel Wishbone timer for the servant SoC. CHANNELS independent
//   WIDTH-bit up-counters advance on a shared count tick, derived from the
//   slow time base through a 2^DIVIDER prescaler. Each channel owns a
//   compare register, enable, one-shot/periodic mode, interrupt enable and
//   a sticky pending flag. Everything runs in the i_clk domain.
//
//   Build option: SERVANT_TIMER_SYNC_EN
//     defined   - i_slow is an asynchronous clock; it is synchronised with
//                 two flops and edge-detected with a third, so slow_tick
//                 fires 3 i_clk cycles after the i_slow rising edge.
//     undefined - i_slow is already a synchronous single-cycle enable and
//                 is used directly as slow_tick.
//
//   Ports
//     i_clk, i_rst   system clock, synchronous active-high reset
//     i_slow         slow time base
//     i_wb_adr       word address: [AW-1:2] channel, [1:0] register
//                    (0 CTRL {ie,periodic,en}, 1 CMP, 2 COUNT, 3 STATUS)
//     i_wb_dat       write data
//     i_wb_we        write enable
//     i_wb_cyc       cycle/strobe
//     o_wb_rdt       registered read data, held until the next access
//     o_wb_ack       single-cycle acknowledge, one cycle after cyc
//     o_irq          OR of all channel irq lines
//     o_ch_irq       per-channel irq = pending & ie (registered)
module servant_multi_timer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DIVIDER  = 0,
  parameter int AW       = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_slow,
  input  logic [AW-1:0]       i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  output logic [31:0]         o_wb_rdt,
  output logic                o_wb_ack,
  output logic                o_irq,
  output logic [CHANNELS-1:0] o_ch_irq
);

  localparam int CW = AW - 2;

  // ---------------------------------------------------------------------
  // Slow tick generation
  // ---------------------------------------------------------------------
  logic slow_tick;

`ifdef SERVANT_TIMER_SYNC_EN
  // [0],[1] form the synchroniser, [2] remembers the previous level so a
  // rising edge yields exactly one i_clk-cycle pulse.
  logic [2:0] slow_sync_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slow_sync_reg <= '0;
    end else begin
      slow_sync_reg <= {slow_sync_reg[1:0], i_slow};
    end
  end

  assign slow_tick = slow_sync_reg[1] & ~slow_sync_reg[2];
`else
  assign slow_tick = i_slow;
`endif

  // ---------------------------------------------------------------------
  // Prescaler: one count tick per 2^DIVIDER slow ticks
  // ---------------------------------------------------------------------
  logic cnt_tick;

  generate
    if (DIVIDER > 0) begin : g_pre
      logic [DIVIDER-1:0] prescale_reg;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          prescale_reg <= '0;
        end else if (slow_tick) begin
          prescale_reg <= prescale_reg + 1'b1;
        end
      end

      assign cnt_tick = slow_tick & (&prescale_reg);
    end else begin : g_nopre
      assign cnt_tick = slow_tick;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic          ack_reg;
  logic [31:0]   rdt_reg;
  logic          wb_fire;
  logic [CW-1:0] ch_sel;
  logic [1:0]    reg_sel;
  logic [31:0]   ch_num;
  logic [31:0]   rd_data;

  // An access takes effect on the edge that raises ack; while ack is high
  // the same cyc does not fire again, so each access acts exactly once.
  assign wb_fire = i_wb_cyc & ~ack_reg;
  assign ch_sel  = i_wb_adr[AW-1:2];
  assign reg_sel = i_wb_adr[1:0];
  assign ch_num  = 32'(ch_sel);

  // Register images of each channel, zero-extended to the bus width.
  logic [31:0] ctrl_word   [CHANNELS];
  logic [31:0] cmp_word    [CHANNELS];
  logic [31:0] count_word  [CHANNELS];
  logic [31:0] status_word [CHANNELS];

  // ---------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             en_reg;
      logic             periodic_reg;
      logic             ie_reg;
      logic             pending_reg;
      logic             irq_reg;
      logic [WIDTH-1:0] cmp_reg;
      logic [WIDTH-1:0] count_reg;

      logic wr_sel;
      logic ctrl_wr;
      logic cmp_wr;
      logic count_wr;
      logic status_wr;
      logic match;

      assign wr_sel    = wb_fire & i_wb_we & (ch_num == 32'(gi));
      assign ctrl_wr   = wr_sel & (reg_sel == 2'd0);
      assign cmp_wr    = wr_sel & (reg_sel == 2'd1);
      assign count_wr  = wr_sel & (reg_sel == 2'd2);
      assign status_wr = wr_sel & (reg_sel == 2'd3);

      // A COUNT write in the same cycle suppresses the tick entirely.
      // ">=" rather than "==" makes a compare lowered below the current
      // count match on the next tick instead of wrapping.
      assign match = cnt_tick & en_reg & ~count_wr & (count_reg >= cmp_reg);

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          en_reg       <= 1'b0;
          periodic_reg <= 1'b0;
          ie_reg       <= 1'b0;
          pending_reg  <= 1'b0;
          irq_reg      <= 1'b0;
          cmp_reg      <= '0;
          count_reg    <= '0;
        end else begin
          // Counter: bus write beats the tick.
          if (count_wr) begin
            count_reg <= '0;
          end else if (cnt_tick & en_reg) begin
            count_reg <= match ? '0 : count_reg + 1'b1;
          end

          // Control: a CTRL write overrides a one-shot self-disable.
          if (ctrl_wr) begin
            en_reg       <= i_wb_dat[0];
            periodic_reg <= i_wb_dat[1];
            ie_reg       <= i_wb_dat[2];
          end else if (match & ~periodic_reg) begin
            en_reg <= 1'b0;
          end

          if (cmp_wr) begin
            cmp_reg <= i_wb_dat[WIDTH-1:0];
          end

          // Pending: a new match beats a simultaneous clear.
          if (match) begin
            pending_reg <= 1'b1;
          end else if (status_wr & i_wb_dat[0]) begin
            pending_reg <= 1'b0;
          end

          irq_reg <= pending_reg & ie_reg;
        end
      end

      assign ctrl_word[gi]   = {29'd0, ie_reg, periodic_reg, en_reg};
      assign cmp_word[gi]    = 32'(cmp_reg);
      assign count_word[gi]  = 32'(count_reg);
      assign status_word[gi] = {31'd0, pending_reg};
      assign o_ch_irq[gi]    = irq_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read mux: channels beyond CHANNELS match no entry and read 0.
  // ---------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_num == 32'(i)) begin
        case (reg_sel)
          2'd0:    rd_data = ctrl_word[i];
          2'd1:    rd_data = cmp_word[i];
          2'd2:    rd_data = count_word[i];
          default: rd_data = status_word[i];
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_reg <= 1'b0;
      rdt_reg <= '0;
    end else begin
      ack_reg <= i_wb_cyc & ~ack_reg;
      if (wb_fire) begin
        rdt_reg <= rd_data;
      end
    end
  end

  assign o_wb_ack = ack_reg;
  assign o_wb_rdt = rdt_reg;
  assign o_irq    = |o_ch_irq;

  // Upper write-data bits have no home when WIDTH < 32.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_wb_dat};

endmodule

// File: tb/tb_servant_multi_timer.sv
// Testbench for servant_multi_timer. Two instances share one bus and slow
// input: dut0 (WIDTH 16, DIVIDER 0) and dut2 (WIDTH 8, DIVIDER 2), both with
// 3 channels and a 4-bit address so channel 3 is out of range. A
// behavioural model tracks both and is compared on every cycle; directed
// sequences add literal expectations.
module tb_servant_multi_timer;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slow = 1'b0;
  logic [3:0]  adr = '0;
  logic [31:0] dat = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;

  logic [31:0]    rdt0, rdt2;
  logic           ack0, ack2, irq0, irq2;
  logic [NCH-1:0] chirq0, chirq2;

  servant_multi_timer #(.WIDTH(16), .CHANNELS(NCH), .DIVIDER(0), .AW(4)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_slow(slow), .i_wb_adr(adr), .i_wb_dat(dat),
    .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt0), .o_wb_ack(ack0),
    .o_irq(irq0), .o_ch_irq(chirq0)
  );

  servant_multi_timer #(.WIDTH(8), .CHANNELS(NCH), .DIVIDER(2), .AW(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_slow(slow), .i_wb_adr(adr), .i_wb_dat(dat),
    .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt2), .o_wb_ack(ack2),
    .o_irq(irq2), .o_ch_irq(chirq2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model (index 0 = dut0, 1 = dut2) --------
  bit          m_ack  [2];
  logic [31:0] m_rdt  [2];
  int unsigned m_slow [2];
  bit          m_en   [2][NCH];
  bit          m_per  [2][NCH];
  bit          m_ie   [2][NCH];
  bit          m_pend [2][NCH];
  bit          m_irq  [2][NCH];
  int unsigned m_cmp  [2][NCH];
  int unsigned m_cnt  [2][NCH];

  function automatic logic [31:0] model_read(input int d, input int c, input int rg);
    case (rg)
      0:       return {29'd0, m_ie[d][c], m_per[d][c], m_en[d][c]};
      1:       return m_cmp[d][c];
      2:       return m_cnt[d][c];
      default: return {31'd0, m_pend[d][c]};
    endcase
  endfunction

  task automatic model_step(input int d);
    int unsigned div_ticks, mask;
    int ch, rg;
    bit fire, tick, wr, matched;
    div_ticks = (d == 0) ? 1 : 4;
    mask      = (d == 0) ? 32'hFFFF : 32'hFF;
    if (rst) begin
      m_ack[d] = 0; m_rdt[d] = 0; m_slow[d] = 0;
      for (int c = 0; c < NCH; c++) begin
        m_en[d][c] = 0; m_per[d][c] = 0; m_ie[d][c] = 0; m_pend[d][c] = 0;
        m_irq[d][c] = 0; m_cmp[d][c] = 0; m_cnt[d][c] = 0;
      end
      return;
    end
    fire = cyc && !m_ack[d];
    tick = 0;
    if (slow) begin
      m_slow[d]++;
      tick = (m_slow[d] % div_ticks) == 0;
    end
    ch = int'(adr[3:2]);
    rg = int'(adr[1:0]);
    if (fire) m_rdt[d] = (ch < NCH) ? model_read(d, ch, rg) : 32'd0;
    m_ack[d] = fire;
    for (int c = 0; c < NCH; c++) m_irq[d][c] = m_pend[d][c] && m_ie[d][c];
    for (int c = 0; c < NCH; c++) begin
      wr = fire && we && (ch == c);
      matched = 0;
      if (tick && m_en[d][c] && !(wr && rg == 2)) begin
        if (m_cnt[d][c] >= m_cmp[d][c]) begin
          matched = 1;
          m_pend[d][c] = 1;
          m_cnt[d][c] = 0;
          if (!m_per[d][c]) m_en[d][c] = 0;
        end else begin
          m_cnt[d][c]++;
        end
      end
      if (wr) begin
        case (rg)
          0: begin m_en[d][c] = dat[0]; m_per[d][c] = dat[1]; m_ie[d][c] = dat[2]; end
          1: m_cmp[d][c] = dat & mask;
          2: m_cnt[d][c] = 0;
          default: if (dat[0] && !matched) m_pend[d][c] = 0;
        endcase
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NCH-1:0] e0, e2;
    if (started) begin
      for (int c = 0; c < NCH; c++) begin
        e0[c] = m_irq[0][c];
        e2[c] = m_irq[1][c];
      end
      check("ack0", 32'(ack0), 32'(m_ack[0]));
      check("rdt0", rdt0, m_rdt[0]);
      check("chirq0", 32'(chirq0), 32'(e0));
      check("irq0", 32'(irq0), 32'(|e0));
      check("ack2", 32'(ack2), 32'(m_ack[1]));
      check("rdt2", rdt2, m_rdt[1]);
      check("chirq2", 32'(chirq2), 32'(e2));
      check("irq2", 32'(irq2), 32'(|e2));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] a, input bit w, input logic [31:0] d,
                    input bit tick_on_fire, output logic [31:0] r0, output logic [31:0] r2);
    adr = a; we = w; dat = d; cyc = 1'b1; slow = tick_on_fire;
    step();
    slow = 1'b0;
    check("wb_ack", 32'(ack0), 32'd1);
    r0 = rdt0;
    r2 = rdt2;
    cyc = 1'b0; we = 1'b0;
    $display("wb %s adr=%0d dat=%0h tick=%0d rdt0=%0h rdt2=%0h",
             w ? "wr" : "rd", a, d, tick_on_fire, r0, r2);
    step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r0, r2;
    wb(a, 1'b1, d, 1'b0, r0, r2);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r0, output logic [31:0] r2);
    wb(a, 1'b0, 32'd0, 1'b0, r0, r2);
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      slow = 1'b1; step();
      slow = 1'b0; step(); step();
    end
  endtask

  // Clear STATUS of the channel at address a (no tick) and watch o_irq
  // hold for one more cycle, then drop.
  task automatic clear_watch(input logic [3:0] a);
    adr = a; we = 1'b1; dat = 32'd1; cyc = 1'b1;
    step();
    check("irq_hold", 32'(irq0), 32'd1);
    cyc = 1'b0; we = 1'b0;
    step();
    check("irq_drop", 32'(irq0), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r0, r2;
    logic [3:0]  ra;
    int          op;

    step(); step();
    rst = 1'b0;
    started = 1'b1;
    check("rst_ack", 32'(ack0), 32'd0);
    check("rst_rdt", rdt0, 32'd0);
    check("rst_irq", 32'(irq0), 32'd0);
    check("rst_chirq", 32'(chirq2), 32'd0);

    // Periodic, ch0 CMP=4, en+periodic+ie.
    wr(4'd1, 32'd4);
    wr(4'd0, 32'd7);
    for (int k = 0; k <= 5; k++) begin
      rd(4'd2, r0, r2);
      check("per_count", r0, 32'(k % 5));
      rd(4'd3, r0, r2);
      check("per_pending", r0, (k == 5) ? 32'd1 : 32'd0);
      if (k < 5) pulse(1);
    end
    check("per_irq", 32'(irq0), 32'd1);
    rd(4'd2, r0, r2);
    check("div4_count", r2, 32'd1);
    wr(4'd0, 32'd4);
    clear_watch(4'd3);

    // One-shot, ch1 CMP=2, en+ie.
    wr(4'd5, 32'd2);
    wr(4'd4, 32'd5);
    pulse(2);
    rd(4'd7, r0, r2);
    check("os_pend_early", r0, 32'd0);
    pulse(1);
    rd(4'd7, r0, r2);
    check("os_pend", r0, 32'd1);
    rd(4'd4, r0, r2);
    check("os_ctrl", r0, 32'd4);
    pulse(10);
    rd(4'd6, r0, r2);
    check("os_count", r0, 32'd0);
    check("os_irq", 32'(irq0), 32'd1);
    wr(4'd4, 32'd4);
    clear_watch(4'd7);
    wr(4'd4, 32'd0);

    // Clear colliding with a match: set wins.
    wr(4'd1, 32'd0);
    wr(4'd0, 32'd7);
    wb(4'd3, 1'b1, 32'd1, 1'b1, r0, r2);
    rd(4'd3, r0, r2);
    check("set_wins", r0, 32'd1);
    wr(4'd0, 32'd4);
    clear_watch(4'd3);
    rd(4'd3, r0, r2);
    check("cleared", r0, 32'd0);

    // Prescaler on dut2: CMP=1 matches on slow tick 8, then every 8.
    do_reset();
    wr(4'd1, 32'd1);
    wr(4'd0, 32'd3);
    for (int rep = 0; rep < 2; rep++) begin
      for (int s = 1; s <= 8; s++) begin
        pulse(1);
        rd(4'd3, r0, r2);
        check("presc_pend", r2, (s == 8) ? 32'd1 : 32'd0);
      end
      wr(4'd3, 32'd1);
    end

    // Write/tick collision.
    do_reset();
    wr(4'd1, 32'd10);
    wr(4'd0, 32'd1);
    pulse(3);
    rd(4'd2, r0, r2);
    check("col_count3", r0, 32'd3);
    wb(4'd2, 1'b1, 32'd0, 1'b1, r0, r2);
    rd(4'd2, r0, r2);
    check("col_count0", r0, 32'd0);
    pulse(3);
    wr(4'd1, 32'd1);
    rd(4'd2, r0, r2);
    check("cmp_low_count", r0, 32'd3);
    rd(4'd3, r0, r2);
    check("cmp_low_nopend", r0, 32'd0);
    pulse(1);
    rd(4'd2, r0, r2);
    check("cmp_low_wrap", r0, 32'd0);
    rd(4'd3, r0, r2);
    check("cmp_low_pend", r0, 32'd1);

    // Reset in the middle of a run and of an access.
    wr(4'd1, 32'd5);
    wr(4'd0, 32'd7);
    pulse(2);
    rd(4'd2, r0, r2);
    check("pre_rst_count", r0, 32'd2);
    check("pre_rst_irq", 32'(irq0), 32'd1);
    adr = 4'd1; we = 1'b1; dat = 32'd9; cyc = 1'b1; rst = 1'b1;
    step();
    check("rst_mid_ack", 32'(ack0), 32'd0);
    check("rst_mid_irq", 32'(irq0), 32'd0);
    check("rst_mid_rdt", rdt0, 32'd0);
    rst = 1'b0; cyc = 1'b0; we = 1'b0;
    step();
    for (int a = 0; a < 4; a++) begin
      rd(4'(a), r0, r2);
      check("post_rst_reg", r0, 32'd0);
    end
    wr(4'd13, 32'd7);
    rd(4'd13, r0, r2);
    check("oor_read", r0, 32'd0);
    rd(4'd5, r0, r2);
    check("oor_noalias", r0, 32'd0);

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 700; i++) begin
      op = $urandom_range(0, 19);
      if (op < 8) begin
        slow = ($urandom_range(0, 2) == 0);
        step();
        slow = 1'b0;
      end else if (op < 19) begin
        ra = 4'($urandom_range(0, 15));
        wb(ra, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), r0, r2);
      end else if ($urandom_range(0, 9) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
